// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: expands one accepted ALU command into per-cycle ALU control strobes and returns the captured ACC/flags.
// Ports: clk/rst (sync, active-high); req_* command channel (valid/ready);
// alu_* control strobes, opcode and data bus out, acc/flags in from the ALU;
// rsp_* response channel (valid/ready) with result, flags and error; busy; op_count.
module alu_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_operand,
  input  logic              req_preserve,
  output logic              alu_ctrl_sig,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              alu_acc_write_en,
  output logic              alu_tmp_write_en,
  output logic              alu_flags_write_en,
  output logic              alu_act_store,
  output logic              alu_act_restore,
  output logic [DATA_W-1:0] alu_data_out,
  input  logic [DATA_W-1:0] alu_acc_in,
  input  logic [DATA_W-1:0] alu_flags_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [DATA_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);
  typedef enum logic [3:0] {IDLE, SAVE, LOAD_TMP, LOAD_ACC, LOAD_FLAGS, EXEC, CAPTURE, RESTORE, RESP} state_t;
  localparam logic [OP_W-1:0] OP_CMP  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_DAA  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_LAST = OP_W'(17);
  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic                save_q, save_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   flags_q, flags_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                accept, req_err, req_save;
  assign accept   = req_valid && state_q == IDLE;
  assign req_err  = req_cmd == 2'b11 || (req_cmd == 2'b00 && (req_op == OP_DAA || req_op > OP_LAST));
  // CMP never touches ACC, so save/restore around it would be pointless
  assign req_save = req_cmd == 2'b00 && req_preserve && req_op != OP_CMP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      operand_q <= '0;
      save_q    <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      save_q    <= save_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    save_d    = save_q;
    result_d  = result_q;
    flags_d   = flags_q;
    err_d     = err_q;
    count_d   = count_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d      = req_op;
        operand_d = req_operand;
        save_d    = req_save;
        err_d     = req_err;
        result_d  = '0;
        flags_d   = '0;
        state_d   = req_err ? RESP :
                    req_cmd == 2'b01 ? LOAD_ACC :
                    req_cmd == 2'b10 ? LOAD_FLAGS :
                    req_save ? SAVE :
                    req_op <= OP_CMP ? LOAD_TMP : EXEC;
      end
      SAVE:       state_d = op_q <= OP_CMP ? LOAD_TMP : EXEC;
      LOAD_TMP:   state_d = EXEC;
      LOAD_ACC:   state_d = CAPTURE;
      LOAD_FLAGS: state_d = CAPTURE;
      EXEC:       state_d = CAPTURE;
      CAPTURE: begin
        result_d = alu_acc_in;
        flags_d  = alu_flags_in;
        state_d  = save_q ? RESTORE : RESP;
      end
      RESTORE:    state_d = RESP;
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        count_d = (err_q || count_q == '1) ? count_q : count_q + CNT_W'(1);
      end
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready          = state_q == IDLE;
    busy               = state_q != IDLE;
    alu_act_store      = state_q == SAVE;
    alu_tmp_write_en   = state_q == LOAD_TMP;
    alu_acc_write_en   = state_q == LOAD_ACC;
    alu_flags_write_en = state_q == LOAD_FLAGS;
    alu_ctrl_sig       = state_q == EXEC;
    alu_act_restore    = state_q == RESTORE;
    alu_opcode         = state_q == IDLE ? '0 : op_q;
    alu_data_out       = (state_q == LOAD_TMP || state_q == LOAD_ACC || state_q == LOAD_FLAGS) ? operand_q : '0;
    rsp_valid          = state_q == RESP;
    rsp_result         = result_q;
    rsp_flags          = flags_q;
    rsp_err            = err_q;
    op_count           = count_q;
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random commands against a transaction-level model with an emulated ALU.
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_preserve;
  logic [1:0]  req_cmd;
  logic [4:0]  req_op, alu_opcode;
  logic [7:0]  req_operand, alu_data_out, alu_acc_in, alu_flags_in, rsp_result, rsp_flags;
  logic        alu_ctrl_sig, alu_acc_write_en, alu_tmp_write_en, alu_flags_write_en, alu_act_store, alu_act_restore;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [15:0] op_count;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  m_acc = 8'h00, m_flags = 8'h00;
  logic [15:0] m_count = 16'h0;
  logic [7:0]  e_acc = 8'h00, e_tmp = 8'h00, e_flags = 8'h00, e_act = 8'h00;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_op(req_op),
    .req_operand(req_operand), .req_preserve(req_preserve),
    .alu_ctrl_sig(alu_ctrl_sig), .alu_opcode(alu_opcode), .alu_acc_write_en(alu_acc_write_en),
    .alu_tmp_write_en(alu_tmp_write_en), .alu_flags_write_en(alu_flags_write_en),
    .alu_act_store(alu_act_store), .alu_act_restore(alu_act_restore), .alu_data_out(alu_data_out),
    .alu_acc_in(alu_acc_in), .alu_flags_in(alu_flags_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );

  // 8080-style ALU behaviour; flags = {6'b0, zero, carry}
  function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, z;
    r = a;
    c = f[0];
    s = 9'h0;
    case (op)
      5'd0:  begin s = {1'b0, a} + {1'b0, b};             r = s[7:0]; c = s[8]; end
      5'd1:  begin s = {1'b0, a} + {1'b0, b} + {8'h0, c}; r = s[7:0]; c = s[8]; end
      5'd2:  begin s = {1'b0, a} - {1'b0, b};             r = s[7:0]; c = s[8]; end
      5'd3:  begin s = {1'b0, a} - {1'b0, b} - {8'h0, c}; r = s[7:0]; c = s[8]; end
      5'd4:  begin r = a & b; c = 1'b0; end
      5'd5:  begin r = a ^ b; c = 1'b0; end
      5'd6:  begin r = a | b; c = 1'b0; end
      5'd7:  begin s = {1'b0, a} - {1'b0, b}; c = s[8]; end
      5'd8:  begin r = {a[6:0], a[7]}; c = a[7]; end
      5'd9:  begin r = {a[0], a[7:1]}; c = a[0]; end
      5'd10: begin r = {a[6:0], c};    c = a[7]; end
      5'd11: begin r = {c, a[7:1]};    c = a[0]; end
      5'd13: r = ~a;
      5'd14: c = 1'b1;
      5'd15: c = ~c;
      5'd16: r = a + 8'd1;
      5'd17: r = a - 8'd1;
      default: ;
    endcase
    z = (op == 5'd7) ? (s[7:0] == 8'h0) : (r == 8'h0);
    return {r, 6'b0, z, c};
  endfunction

  always @(posedge clk) begin
    if (alu_tmp_write_en) e_tmp <= alu_data_out;
    if (alu_flags_write_en) e_flags <= alu_data_out;
    if (alu_act_store) e_act <= e_acc;
    if (alu_acc_write_en) e_acc <= alu_data_out;
    else if (alu_act_restore) e_acc <= e_act;
    else if (alu_ctrl_sig) {e_acc, e_flags} <= alu_fn(alu_opcode, e_acc, e_tmp, e_flags);
  end
  assign alu_acc_in   = e_acc;
  assign alu_flags_in = e_flags;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 1=act_store 2=tmp 3=acc 4=flags 5=ctrl 6=none 7=restore 8=several at once
  function automatic logic [3:0] strobe_code();
    int n;
    n = $countones({alu_act_store, alu_tmp_write_en, alu_acc_write_en, alu_flags_write_en, alu_ctrl_sig, alu_act_restore});
    return n > 1 ? 4'd8 : alu_act_store ? 4'd1 : alu_tmp_write_en ? 4'd2 : alu_acc_write_en ? 4'd3 :
           alu_flags_write_en ? 4'd4 : alu_ctrl_sig ? 4'd5 : alu_act_restore ? 4'd7 : 4'd6;
  endfunction

  task automatic run_cmd(input logic [1:0] cmd, input logic [4:0] op, input logic [7:0] opd, input logic pre,
                         input int bp, input bit hold);
    logic [63:0] et, tr;
    logic [15:0] r;
    logic [7:0]  er, ef, exp_data;
    logic [3:0]  c;
    int          el, lat, t, bus_bad, stable_bad;
    bit          err, save;
    et = '0; tr = '0; el = 0; bus_bad = 0; stable_bad = 0;
    err  = cmd == 2'd3 || (cmd == 2'd0 && (op == 5'd12 || op > 5'd17));
    save = cmd == 2'd0 && pre && op != 5'd7 && !err;
    er = 8'h00; ef = 8'h00;
    if (err) begin
    end else if (cmd == 2'd1) begin
      et = {et[59:0], 4'd3}; et = {et[59:0], 4'd6}; el = 2;
      er = opd; ef = m_flags; m_acc = opd;
    end else if (cmd == 2'd2) begin
      et = {et[59:0], 4'd4}; et = {et[59:0], 4'd6}; el = 2;
      er = m_acc; ef = opd; m_flags = opd;
    end else begin
      if (save) begin et = {et[59:0], 4'd1}; el++; end
      if (op <= 5'd7) begin et = {et[59:0], 4'd2}; el++; end
      et = {et[59:0], 4'd5}; et = {et[59:0], 4'd6}; el += 2;
      if (save) begin et = {et[59:0], 4'd7}; el++; end
      r = alu_fn(op, m_acc, opd, m_flags);
      er = r[15:8]; ef = r[7:0]; m_flags = ef;
      if (!save) m_acc = er;
    end
    req_cmd = cmd; req_op = op; req_operand = opd; req_preserve = pre; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("accept_wait", 32'(t < 50), 32'd1);
    @(posedge clk); #1;
    if (hold) begin
      req_cmd = 2'd1; req_op = 5'd0; req_operand = 8'h3C; req_preserve = 1'b0;
    end else begin
      req_valid = 1'b0; req_cmd = 2'($urandom); req_op = 5'($urandom); req_operand = 8'($urandom); req_preserve = 1'($urandom);
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      c = strobe_code();
      exp_data = (c == 4'd2 || c == 4'd3 || c == 4'd4) ? opd : 8'h00;
      if (alu_data_out !== exp_data || alu_opcode !== op) bus_bad++;
      tr = {tr[59:0], c};
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, el + 1);
    chk("strobe_trace", tr[31:0], et[31:0]);
    chk("bus_values", bus_bad, 0);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, err});
    chk("rsp_result", {24'b0, rsp_result}, {24'b0, er});
    chk("rsp_flags", {24'b0, rsp_flags}, {24'b0, ef});
    chk("rsp_strobes", {28'b0, strobe_code()}, 32'd6);
    chk("rsp_handshake_gate", {30'b0, req_ready, busy}, 32'b01);
    repeat (bp) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_result !== er || rsp_flags !== ef || rsp_err !== err || req_ready || strobe_code() != 4'd6) stable_bad++;
    end
    if (bp > 0) chk("backpressure_stable", stable_bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (!err && m_count != 16'hFFFF) m_count++;
    chk("op_count", {16'b0, op_count}, {16'b0, m_count});
    chk("alu_acc_after", {24'b0, e_acc}, {24'b0, m_acc});
    chk("idle_after", {30'b0, rsp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    int t;
    rst = 1'b1; req_valid = 1'b0; req_cmd = 2'd0; req_op = 5'd0; req_operand = 8'h00; req_preserve = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("reset_state", {op_count, 8'b0, rsp_result}, 32'h0);
    chk("reset_ctrl", {25'b0, busy, rsp_valid, rsp_err, strobe_code()}, 32'h6);
    rst = 1'b0;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    run_cmd(2'd1, 5'd0, 8'h03, 1'b0, 0, 1'b0);
    run_cmd(2'd0, 5'd0, 8'h05, 1'b0, 0, 1'b0);
    chk("add_result", {24'b0, rsp_result}, 32'h08);
    run_cmd(2'd1, 5'd0, 8'h7F, 1'b0, 0, 1'b0);
    run_cmd(2'd0, 5'd16, 8'h00, 1'b1, 0, 1'b0);
    chk("inr_result", {24'b0, rsp_result}, 32'h80);
    chk("inr_acc_restored", {24'b0, e_acc}, 32'h7F);
    run_cmd(2'd0, 5'd7, 8'h10, 1'b1, 0, 1'b0);
    chk("cmp_result", {24'b0, rsp_result}, 32'h7F);
    run_cmd(2'd0, 5'd0, 8'h21, 1'b1, 0, 1'b0);
    run_cmd(2'd0, 5'd12, 8'h44, 1'b0, 0, 1'b0);
    run_cmd(2'd3, 5'd0, 8'h44, 1'b1, 0, 1'b0);
    run_cmd(2'd0, 5'd20, 8'h44, 1'b0, 2, 1'b0);
    run_cmd(2'd2, 5'd3, 8'h01, 1'b0, 0, 1'b0);
    run_cmd(2'd0, 5'd0, 8'h22, 1'b0, 10, 1'b1);
    run_cmd(2'd1, 5'd0, 8'h3C, 1'b0, 0, 1'b0);
    // reset in the middle of an ADD while the execute strobe is up
    req_cmd = 2'd0; req_op = 5'd0; req_operand = 8'h11; req_preserve = 1'b1; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    t = 0;
    while (!alu_ctrl_sig && t < 10) begin @(posedge clk); #1; t++; end
    chk("reached_exec", {31'b0, alu_ctrl_sig}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_ctrl", {25'b0, busy, rsp_valid, rsp_err, strobe_code()}, 32'h6);
    chk("midreset_data", {op_count, 8'b0, rsp_result}, 32'h0);
    chk("midreset_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("midreset_no_restore", {28'b0, strobe_code()}, 32'd6);
    m_count = 16'h0; m_acc = e_acc; m_flags = e_flags;
    run_cmd(2'd1, 5'd0, 8'hA5, 1'b0, 0, 1'b0);
    chk("load_a5", {24'b0, rsp_result}, 32'hA5);
    for (int i = 0; i < 60; i++) begin
      logic [1:0] cmd;
      logic [4:0] op;
      cmd = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
      op  = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 17)) : 5'($urandom_range(0, 31));
      run_cmd(cmd, op, 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
